// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// mux selects and the bundle of control strobes driven each cycle.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXEC_R = 4'd2,
      EXEC_I = 4'd3,
      MEM_RD = 4'd4,
      MEM_WR = 4'd5,
      WB_ALU = 4'd6,
      WB_MEM = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      TRAP   = 4'd10
   } state_t;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUB_RT     = 2'b00;
   localparam logic [1:0] ALUB_FOUR   = 2'b01;
   localparam logic [1:0] ALUB_IMM    = 2'b10;
   localparam logic [1:0] ALUB_IMM_SH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       instr_done;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = ctrl_t'(16'h0000);

endpackage

// File: rtl/ctrl_timeout_timer.sv
// Counts consecutive cycles of an unanswered memory request and flags expiry
// in the cycle the count reaches the limit while the request is still pending.
module ctrl_timeout_timer #(
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_r;

   // wait counter; saturates so a disabled timeout never wraps
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (run && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   assign expired = (TIMEOUT_CYCLES > 32'sd0) && run && (cnt_r == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencing FSM: per-state control strobes for PC, IR, the
// shared memory port, ALU muxes and register write, with sticky trap flags.
module multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       bus_err,
   output logic [3:0] state_o
);

   state_t     state_r, next_s;
   logic [5:0] op_r;
   logic       illegal_r, bus_err_r;
   ctrl_t      ctrl_s, ctrl_out_s;
   logic       illegal_set_s, mem_state_s, run_s, clr_s, expired_s;

   // run is derived from state, not from ctrl_s, to keep the decode loop-free
   assign mem_state_s = (state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR);
   assign run_s       = mem_state_s && !mem_ack;
   assign clr_s       = mem_ack || (next_s != state_r);

   ctrl_timeout_timer #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (run_s),
      .clr     (clr_s),
      .expired (expired_s)
   );

   // state register, opcode latch and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= FETCH;
         op_r      <= 6'd0;
         illegal_r <= 1'b0;
         bus_err_r <= 1'b0;
      end else begin
         state_r <= next_s;
         if (state_r == DECODE) op_r <= opcode;
         if (illegal_set_s) illegal_r <= 1'b1;
         if (expired_s) bus_err_r <= 1'b1;
      end
   end

   // next-state and per-state control decode
   always_comb begin
      ctrl_s        = CTRL_NONE;
      next_s        = state_r;
      illegal_set_s = 1'b0;
      case (state_r)
         FETCH: begin
            ctrl_s.mem_req   = 1'b1;
            ctrl_s.alu_src_b = ALUB_FOUR;
            ctrl_s.alu_op    = ALUOP_ADD;
            if (mem_ack) begin
               ctrl_s.ir_write = 1'b1;
               ctrl_s.pc_write = 1'b1;
               ctrl_s.pc_src   = PC_SRC_ALU;
               next_s          = DECODE;
            end else if (expired_s) begin
               next_s = TRAP;
            end else begin
               next_s = FETCH;
            end
         end
         DECODE: begin
            ctrl_s.alu_src_b = ALUB_IMM_SH;
            ctrl_s.alu_op    = ALUOP_ADD;
            case (opcode)
               OP_RTYPE:              next_s = EXEC_R;
               OP_ADDI, OP_LW, OP_SW: next_s = EXEC_I;
               OP_BEQ, OP_BNE:        next_s = BRANCH;
               OP_J:                  next_s = JUMP;
               default: begin
                  next_s        = TRAP;
                  illegal_set_s = 1'b1;
               end
            endcase
         end
         EXEC_R: begin
            ctrl_s.alu_src_a = 1'b1;
            ctrl_s.alu_src_b = ALUB_RT;
            ctrl_s.alu_op    = ALUOP_FUNCT;
            next_s           = WB_ALU;
         end
         EXEC_I: begin
            ctrl_s.alu_src_a = 1'b1;
            ctrl_s.alu_src_b = ALUB_IMM;
            ctrl_s.alu_op    = ALUOP_ADD;
            case (op_r)
               OP_LW:   next_s = MEM_RD;
               OP_SW:   next_s = MEM_WR;
               default: next_s = WB_ALU;
            endcase
         end
         MEM_RD: begin
            ctrl_s.mem_req = 1'b1;
            ctrl_s.i_or_d  = 1'b1;
            if (mem_ack) begin
               next_s = WB_MEM;
            end else if (expired_s) begin
               next_s = TRAP;
            end else begin
               next_s = MEM_RD;
            end
         end
         MEM_WR: begin
            ctrl_s.mem_req = 1'b1;
            ctrl_s.mem_we  = 1'b1;
            ctrl_s.i_or_d  = 1'b1;
            if (mem_ack) begin
               ctrl_s.instr_done = 1'b1;
               next_s            = FETCH;
            end else if (expired_s) begin
               next_s = TRAP;
            end else begin
               next_s = MEM_WR;
            end
         end
         WB_ALU: begin
            ctrl_s.reg_write  = 1'b1;
            ctrl_s.reg_dst    = (op_r == OP_RTYPE);
            ctrl_s.instr_done = 1'b1;
            next_s            = FETCH;
         end
         WB_MEM: begin
            ctrl_s.reg_write  = 1'b1;
            ctrl_s.mem_to_reg = 1'b1;
            ctrl_s.instr_done = 1'b1;
            next_s            = FETCH;
         end
         BRANCH: begin
            ctrl_s.alu_src_a  = 1'b1;
            ctrl_s.alu_src_b  = ALUB_RT;
            ctrl_s.alu_op     = ALUOP_SUB;
            ctrl_s.pc_src     = PC_SRC_ALUOUT;
            ctrl_s.pc_write   = ((op_r == OP_BEQ) && zero) || ((op_r == OP_BNE) && !zero);
            ctrl_s.instr_done = 1'b1;
            next_s            = FETCH;
         end
         JUMP: begin
            ctrl_s.pc_write   = 1'b1;
            ctrl_s.pc_src     = PC_SRC_JUMP;
            ctrl_s.instr_done = 1'b1;
            next_s            = FETCH;
         end
         TRAP:    next_s = TRAP;
         default: next_s = TRAP;
      endcase
   end

   // reset silences every output in the same cycle, including a pending request
   assign ctrl_out_s = rst ? CTRL_NONE : ctrl_s;

   assign mem_req    = ctrl_out_s.mem_req;
   assign mem_we     = ctrl_out_s.mem_we;
   assign i_or_d     = ctrl_out_s.i_or_d;
   assign ir_write   = ctrl_out_s.ir_write;
   assign pc_write   = ctrl_out_s.pc_write;
   assign pc_src     = ctrl_out_s.pc_src;
   assign alu_src_a  = ctrl_out_s.alu_src_a;
   assign alu_src_b  = ctrl_out_s.alu_src_b;
   assign alu_op     = ctrl_out_s.alu_op;
   assign reg_write  = ctrl_out_s.reg_write;
   assign reg_dst    = ctrl_out_s.reg_dst;
   assign mem_to_reg = ctrl_out_s.mem_to_reg;
   assign instr_done = ctrl_out_s.instr_done;
   assign illegal_op = illegal_r && !rst;
   assign bus_err    = bus_err_r && !rst;
   assign state_o    = rst ? 4'd0 : state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: an instruction-level model expands each instruction into
// expected per-cycle outputs and retire latency, checked with immediate asserts.
module tb_multicycle_controller;

   localparam int T = 4;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_EXEC_R = 4'd2;
   localparam logic [3:0] S_EXEC_I = 4'd3;
   localparam logic [3:0] S_MEM_RD = 4'd4;
   localparam logic [3:0] S_MEM_WR = 4'd5;
   localparam logic [3:0] S_WB_ALU = 4'd6;
   localparam logic [3:0] S_WB_MEM = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;
   localparam logic [3:0] S_TRAP   = 4'd10;

   logic       clk = 1'b0;
   logic       rst, zero, mem_ack;
   logic [5:0] opcode;
   logic       mem_req, mem_we, i_or_d, ir_write, pc_write, alu_src_a;
   logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal_op, bus_err;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [3:0] state_o;
   logic [21:0] obs;

   always #5 clk = ~clk;

   multicycle_controller #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
      .illegal_op(illegal_op), .bus_err(bus_err), .state_o(state_o)
   );

   assign obs = {state_o, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                 alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
                 instr_done, illegal_op, bus_err};

   typedef struct packed {
      logic [21:0] exp;
      logic        ack;
      logic [5:0]  op;
      logic        z;
   } step_t;

   step_t q[$];
   int    total = 0;
   int    bad = 0;
   int    exp_lat = 0;
   logic  ill_m = 1'b0;
   logic  berr_m = 1'b0;

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [5:0] ro();
      return 6'($urandom);
   endfunction

   function automatic logic [15:0] ctl(input logic mrq, input logic mwe, input logic iod,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                       input logic rw, input logic rd, input logic mtr, input logic dn);
      return {mrq, mwe, iod, irw, pcw, pcs, asa, asb, aop, rw, rd, mtr, dn};
   endfunction

   task automatic push(input logic [3:0] st, input logic [15:0] c, input logic ack,
                       input logic [5:0] op, input logic z);
      step_t s;
      s.exp = {st, c, ill_m, berr_m};
      s.ack = ack;
      s.op  = op;
      s.z   = z;
      q.push_back(s);
   endtask

   task automatic push_trap();
      for (int i = 0; i < 20; i++) push(S_TRAP, 16'h0000, rb(), ro(), rb());
   endtask

   // a memory-request phase of d wait cycles; a wait longer than T ends in TRAP
   task automatic mem_phase(input logic [3:0] st, input logic we, input int d, output logic ok);
      int   n;
      logic a, f;
      n = (d > T) ? T : d;
      f = (st == S_FETCH);
      for (int i = 0; i <= n; i++) begin
         a = (i == d);
         push(st, ctl(1'b1, we, !f, a & f, a & f, 2'b00, 1'b0, f ? 2'b01 : 2'b00,
                      2'b00, 1'b0, 1'b0, 1'b0, a & we), a, ro(), rb());
      end
      ok = (d <= T);
      if (!ok) begin
         berr_m = 1'b1;
         push_trap();
      end
   endtask

   task automatic build(input logic [5:0] op, input logic z, input int fd, input int md);
      logic ok;
      exp_lat = 0;
      mem_phase(S_FETCH, 1'b0, fd, ok);
      if (!ok) return;
      push(S_DECODE, ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 2'b00,
                         1'b0, 1'b0, 1'b0, 1'b0), rb(), op, rb());
      case (op)
         6'b000000: begin
            push(S_EXEC_R, ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b10,
                               1'b0, 1'b0, 1'b0, 1'b0), rb(), ro(), rb());
            push(S_WB_ALU, ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00,
                               1'b1, 1'b1, 1'b0, 1'b1), rb(), ro(), rb());
            exp_lat = 4 + fd;
         end
         6'b001000, 6'b100011, 6'b101011: begin
            push(S_EXEC_I, ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b00,
                               1'b0, 1'b0, 1'b0, 1'b0), rb(), ro(), rb());
            if (op == 6'b001000) begin
               push(S_WB_ALU, ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00,
                                  1'b1, 1'b0, 1'b0, 1'b1), rb(), ro(), rb());
               exp_lat = 4 + fd;
            end else if (op == 6'b100011) begin
               mem_phase(S_MEM_RD, 1'b0, md, ok);
               if (ok) begin
                  push(S_WB_MEM, ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00,
                                     1'b1, 1'b0, 1'b1, 1'b1), rb(), ro(), rb());
                  exp_lat = 5 + fd + md;
               end
            end else begin
               mem_phase(S_MEM_WR, 1'b1, md, ok);
               if (ok) exp_lat = 4 + fd + md;
            end
         end
         6'b000100, 6'b000101: begin
            push(S_BRANCH, ctl(1'b0, 1'b0, 1'b0, 1'b0, (op == 6'b000100) ? z : !z, 2'b01,
                               1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1), rb(), ro(), z);
            exp_lat = 3 + fd;
         end
         6'b000010: begin
            push(S_JUMP, ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00,
                             1'b0, 1'b0, 1'b0, 1'b1), rb(), ro(), rb());
            exp_lat = 3 + fd;
         end
         default: begin
            ill_m = 1'b1;
            push_trap();
         end
      endcase
   endtask

   task automatic run_queue(input int limit, input logic chk);
      step_t s;
      int    k;
      int    seen;
      k    = 0;
      seen = 0;
      while (q.size() > 0 && k < limit) begin
         s = q.pop_front();
         @(posedge clk);
         #1;
         rst     = 1'b0;
         mem_ack = s.ack;
         opcode  = s.op;
         zero    = s.z;
         @(negedge clk);
         total++;
         assert (obs === s.exp) else begin
            bad++;
            $error("FAIL step%0d state=%0d observed=%h expected=%h", k, state_o, obs, s.exp);
         end
         if (instr_done === 1'b1 && seen == 0) seen = k + 1;
         k++;
      end
      q.delete();
      if (chk && exp_lat != 0) begin
         total++;
         assert (seen == exp_lat) else begin
            bad++;
            $error("FAIL latency observed=%0d expected=%0d", seen, exp_lat);
         end
      end
   endtask

   // one checked reset cycle; the following clock edge applies it
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst     = 1'b1;
      mem_ack = rb();
      opcode  = ro();
      zero    = rb();
      @(negedge clk);
      total++;
      assert (obs === 22'd0) else begin
         bad++;
         $error("FAIL reset_outputs observed=%h expected=%h", obs, 22'd0);
      end
      ill_m  = 1'b0;
      berr_m = 1'b0;
   endtask

   initial begin
      int fd, md;
      rst     = 1'b1;
      mem_ack = 1'b0;
      opcode  = 6'd0;
      zero    = 1'b0;
      repeat (3) @(posedge clk);
      do_reset();

      build(6'b001000, 1'b0, 0, 0); run_queue(1000, 1'b1);
      build(6'b100011, 1'b0, 3, 3); run_queue(1000, 1'b1);
      build(6'b000100, 1'b1, 0, 0); run_queue(1000, 1'b1);
      build(6'b000100, 1'b0, 0, 0); run_queue(1000, 1'b1);
      build(6'b000101, 1'b1, 0, 0); run_queue(1000, 1'b1);
      build(6'b000101, 1'b0, 0, 0); run_queue(1000, 1'b1);
      build(6'b000000, 1'b0, 1, 0); run_queue(1000, 1'b1);
      build(6'b101011, 1'b0, 0, 2); run_queue(1000, 1'b1);
      build(6'b000010, 1'b0, 2, 0); run_queue(1000, 1'b1);

      build(6'b111111, 1'b0, 0, 0); run_queue(1000, 1'b1);
      do_reset();
      build(6'b001000, 1'b0, 7, 0); run_queue(1000, 1'b1);
      do_reset();
      build(6'b001000, 1'b0, 4, 0); run_queue(1000, 1'b1);

      // reset while MEM_WR is still waiting for its ack
      build(6'b101011, 1'b0, 0, 3); run_queue(5, 1'b0);
      do_reset();
      build(6'b001000, 1'b0, 0, 0); run_queue(1000, 1'b1);

      for (int n = 0; n < 80; n++) begin
         fd = ($urandom_range(9, 0) == 0) ? 5 : $urandom_range(3, 0);
         md = ($urandom_range(9, 0) == 0) ? 5 : $urandom_range(4, 0);
         case ($urandom_range(8, 0))
            0:       build(6'b000000, rb(), fd, md);
            1:       build(6'b001000, rb(), fd, md);
            2:       build(6'b100011, rb(), fd, md);
            3:       build(6'b101011, rb(), fd, md);
            4:       build(6'b000010, rb(), fd, md);
            5:       build(6'b000100, rb(), fd, md);
            6:       build(6'b000101, rb(), fd, md);
            default: build(ro(), rb(), fd, md);
         endcase
         run_queue(1000, 1'b1);
         if (ill_m || berr_m) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
